// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default element width, matrix-slot geometry and the
// matrix loader state encoding.
package tpu_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned MAT_ELEMS = 4;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loader_state_t;

  // Memory address of element idx of matrix slot: {slot, idx}.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [SLOT_W-1:0] slot,
                                                  input logic [CNT_W-1:0]  idx);
    return {slot, idx};
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Matrix loader: accepts a row-major stream of MAT_ELEMS elements per matrix
// and writes them into one of NUM_SLOTS slots of the downstream memory.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready element beat handshake; in_data element value
//   in_sel            target slot, sampled on the first beat of a matrix only
//   hold              consumer stall, forces in_ready low
//   clear_loaded      clears all slot_loaded flags
//   mem_write_en/addr/data  registered memory write port (1-cycle latency)
//   slot_loaded       per-slot "fully written" flags
//   load_done         one-cycle pulse in the cycle after the last beat
module matrix_loader
  import tpu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SLOT_W-1:0]    in_sel,
  output logic                 in_ready,
  input  logic                 hold,
  input  logic                 clear_loaded,
  output logic                 mem_write_en,
  output logic [ADDR_W-1:0]    mem_write_addr,
  output logic [WIDTH-1:0]     mem_data,
  output logic [NUM_SLOTS-1:0] slot_loaded,
  output logic                 load_done
);

  loader_state_t     state;
  logic [CNT_W-1:0]  count;
  logic [SLOT_W-1:0] slot;
  logic              accept;

  // Ready depends on state and hold only; held low during reset.
  assign in_ready = !rst && !hold && (state != LD_DONE);
  assign accept   = in_valid && in_ready;

  // Loader FSM with inline element counter, slot latch and flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= LD_IDLE;
      count          <= '0;
      slot           <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_data       <= '0;
      slot_loaded    <= '0;
      load_done      <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      load_done    <= 1'b0;
      if (clear_loaded) slot_loaded <= '0;

      case (state)
        LD_IDLE: begin
          if (accept) begin
            slot           <= in_sel;
            count          <= CNT_W'(1);
            mem_write_en   <= 1'b1;
            mem_write_addr <= elem_addr(in_sel, CNT_W'(0));
            mem_data       <= in_data;
            state          <= LD_LOAD;
          end
        end

        LD_LOAD: begin
          if (accept) begin
            mem_write_en   <= 1'b1;
            mem_write_addr <= elem_addr(slot, count);
            mem_data       <= in_data;
            if (count == CNT_W'(MAT_ELEMS - 1)) begin
              // Pulse aligns with the DONE cycle.
              load_done <= 1'b1;
              state     <= LD_DONE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end

        LD_DONE: begin
          // Later assignment wins over the clear above for this slot's bit.
          slot_loaded[slot] <= 1'b1;
          count             <= '0;
          state             <= LD_IDLE;
        end

        default: begin
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: a driver updates a behavioural model
// of accepted beats, slot flags and DONE timing; a monitor compares every cycle.
module tb_matrix_loader;
  import tpu_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    logic [3:0]   addr;
    logic [W-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid, hold, clear_loaded;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_ready;
  logic           mem_write_en;
  logic [3:0]     mem_write_addr;
  logic [W-1:0]   mem_data;
  logic [3:0]     slot_loaded;
  logic           load_done;

  matrix_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel), .in_ready(in_ready), .hold(hold),
    .clear_loaded(clear_loaded), .mem_write_en(mem_write_en),
    .mem_write_addr(mem_write_addr), .mem_data(mem_data),
    .slot_loaded(slot_loaded), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  wr_t        wq[$];
  int         m_idx = 0;
  int         m_slot = 0;
  logic [3:0] m_flags = 4'b0;
  bit         m_done_cyc = 1'b0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One input cycle: drive at negedge, check ready, advance the model.
  task automatic drive(input bit v, input logic [W-1:0] d, input logic [1:0] s,
                       input bit h, input bit c);
    bit exp_rdy;
    @(negedge clk);
    in_valid = v; in_data = d; in_sel = s; hold = h; clear_loaded = c;
    #1;
    exp_rdy = !h && !m_done_cyc;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_done_cyc) begin
      if (c) m_flags = 4'b0;
      m_flags[m_slot] = 1'b1;
      m_done_cyc = 1'b0;
    end else if (c) begin
      m_flags = 4'b0;
    end
    if (v && exp_rdy) begin
      if (m_idx == 0) m_slot = int'(s);
      wq.push_back('{addr: 4'(m_slot * 4 + m_idx), data: d});
      m_idx++;
      if (m_idx == 4) begin
        m_idx = 0;
        m_done_cyc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, W'(0), 2'd0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [W-1:0] d, input logic [1:0] s);
    drive(1'b1, d, s, 1'b0, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wen"}, 32'(mem_write_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_write_addr), 32'd0);
    chk({tag, "_data"}, 32'(mem_data), 32'd0);
    chk({tag, "_flags"}, 32'(slot_loaded), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, then release.
  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0; hold = 1'b0; clear_loaded = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    wq.delete();
    m_idx = 0; m_slot = 0; m_flags = 4'b0; m_done_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares write port, done pulse and flags against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("mem_write_en", 32'(mem_write_en), 32'(wq.size() != 0));
        if (mem_write_en && wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("mem_write_addr", 32'(mem_write_addr), 32'(e.addr));
          chk("mem_data", 32'(mem_data), 32'(e.data));
        end
        chk("load_done", 32'(load_done), 32'(m_done_cyc));
        chk("slot_loaded", 32'(slot_loaded), 32'(m_flags));
      end
    end
  end

  initial begin
    in_valid = 1'b0; in_data = '0; in_sel = '0; hold = 1'b0; clear_loaded = 1'b0;
    #1;
    chk_zero_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Full-rate load into slot 2
    beat(W'(11), 2'd2); beat(W'(22), 2'd2); beat(W'(33), 2'd2); beat(W'(44), 2'd2);
    idle(2);
    chk("full_rate_flags", 32'(slot_loaded), 32'h4);

    // Bubbles and hold into slot 0
    beat(W'(10), 2'd0);
    idle(1);
    beat(W'(20), 2'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, W'(8'hEE), 2'd3, 1'b1, 1'b0);
    beat(W'(30), 2'd2);
    idle(2);
    beat(W'(40), 2'd3);
    idle(2);
    chk("hold_flags", 32'(slot_loaded), 32'h5);

    // in_sel changes mid-matrix are ignored
    beat(W'(1), 2'd1); beat(W'(2), 2'd3); beat(W'(3), 2'd3); beat(W'(4), 2'd3);
    idle(2);
    chk("sel_change_flags", 32'(slot_loaded), 32'h7);

    // Clear/set collision in the slot-1 DONE cycle
    drive(1'b0, W'(0), 2'd0, 1'b0, 1'b1);
    idle(1);
    chk("clear_flags", 32'(slot_loaded), 32'h0);
    for (int i = 0; i < 4; i++) beat(W'(50 + i), 2'd0);
    idle(1);
    for (int i = 0; i < 4; i++) beat(W'(60 + i), 2'd3);
    idle(2);
    chk("pre_collision_flags", 32'(slot_loaded), 32'h9);
    for (int i = 0; i < 4; i++) beat(W'(70 + i), 2'd1);
    drive(1'b0, W'(0), 2'd0, 1'b0, 1'b1);
    idle(2);
    chk("collision_flags", 32'(slot_loaded), 32'h2);

    // Reset mid-load of slot 3, then a fresh slot-3 load from addr 12
    beat(W'(90), 2'd3); beat(W'(91), 2'd3);
    reset_mid();
    idle(3);
    for (int i = 0; i < 4; i++) beat(W'(100 + i), 2'd3);
    idle(2);
    chk("after_reset_flags", 32'(slot_loaded), 32'h8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), W'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 39) == 0));
    end
    idle(8);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
